// File: rtl/line_clear_sequencer_if.sv
// Row-wide board memory port: one registered read (1-cycle latency) and one write per cycle.
interface line_clear_sequencer_if #(
    parameter int BLOCKS_W = 10
);
    logic [4:0]          rd_addr;
    logic [BLOCKS_W-1:0] rd_data;
    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [BLOCKS_W-1:0] wr_data;

    modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data);
    modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/line_clear_sequencer.sv
// Bottom-up board compaction: drops full rows, shifts survivors down, zero-fills the top rows,
// and counts cleared rows into a 3-digit BCD score.
module line_clear_sequencer #(
    parameter int BLOCKS_W = 10,
    parameter int BLOCKS_H = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       clear_score,
    output logic       busy,
    output logic       done,
    output logic [2:0] lines_cleared,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic [3:0] score_3,
    line_clear_sequencer_if.master brd
);
    localparam logic [4:0] LAST_ROW = 5'(BLOCKS_H - 1);

    typedef enum logic [2:0] {IDLE, READ, EVAL, FILL, DONE} state_t;

    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    state_t     state, state_nx;
    logic [4:0] src, dst, rd_addr_q;
    bcd_t       score;
    logic       done_q;
    logic       row_full;

    assign row_full    = &brd.rd_data;
    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign brd.rd_addr = rd_addr_q;
    assign score_1     = score.ones;
    assign score_2     = score.tens;
    assign score_3     = score.hundreds;

    function automatic bcd_t bcd_inc(input bcd_t s);
        bcd_t r;
        r = s;
        if (s.ones != 4'd9) begin
            r.ones = s.ones + 4'd1;
        end else begin
            r.ones = 4'd0;
            if (s.tens != 4'd9) begin
                r.tens = s.tens + 4'd1;
            end else begin
                r.tens     = 4'd0;
                r.hundreds = (s.hundreds == 4'd9) ? 4'd0 : s.hundreds + 4'd1;
            end
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
        state_nx    = state;
        brd.wr_en   = 1'b0;
        brd.wr_addr = 5'd0;
        brd.wr_data = {BLOCKS_W{1'b0}};
        case (state)
            IDLE: if (start) state_nx = READ;
            READ: state_nx = EVAL;
            EVAL: begin
                if (!row_full) begin
                    brd.wr_en   = 1'b1;
                    brd.wr_addr = dst;
                    brd.wr_data = brd.rd_data;
                end
                // The row being judged now counts towards "anything cleared?".
                if (src != 5'd0)                             state_nx = READ;
                else if (row_full || lines_cleared != 3'd0)  state_nx = FILL;
                else                                         state_nx = DONE;
            end
            FILL: begin
                brd.wr_en   = 1'b1;
                brd.wr_addr = dst;
                if (dst == 5'd0) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            src           <= 5'd0;
            dst           <= 5'd0;
            rd_addr_q     <= 5'd0;
            lines_cleared <= 3'd0;
            score         <= '0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            state  <= state_nx;
            // done is a registered echo of DONE, so the pulse lands one cycle after that state.
            done_q <= (state == DONE);
            case (state)
                IDLE: begin
                    if (clear_score) score <= '0;
                    if (start) begin
                        src           <= LAST_ROW;
                        dst           <= LAST_ROW;
                        rd_addr_q     <= LAST_ROW;
                        lines_cleared <= 3'd0;
                    end
                end
                EVAL: begin
                    if (row_full) begin
                        if (lines_cleared != 3'd7) lines_cleared <= lines_cleared + 3'd1;
                        score <= bcd_inc(score);
                    end else begin
                        dst <= dst - 5'd1;
                    end
                    if (src != 5'd0) begin
                        src       <= src - 5'd1;
                        rd_addr_q <= src - 5'd1;
                    end
                end
                // After compaction dst sits on the lowest row still to be zeroed (count-1).
                FILL: if (dst != 5'd0) dst <= dst - 5'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_line_clear_sequencer.sv
// Self-checking bench: board RAM with 1-cycle read latency, golden compaction model, per-cycle compare.
module tb_line_clear_sequencer;
  localparam int W = 10;
  localparam int H = 20;

  typedef struct {
    int             cyc;
    logic [4:0]     addr;
    logic [W-1:0]   data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       clear_score = 1'b0;
  logic       busy, done;
  logic [2:0] lines_cleared;
  logic [3:0] score_1, score_2, score_3;

  line_clear_sequencer_if #(.BLOCKS_W(W)) brd ();

  line_clear_sequencer #(.BLOCKS_W(W), .BLOCKS_H(H)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear_score(clear_score),
    .busy(busy), .done(done), .lines_cleared(lines_cleared),
    .score_1(score_1), .score_2(score_2), .score_3(score_3), .brd(brd)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem   [H];
  logic [W-1:0] board [H];
  logic [W-1:0] gold  [H];
  logic         load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int r = 0; r < H; r++) mem[r] <= board[r];
    end else if (brd.wr_en === 1'b1 && brd.wr_addr < 5'(H)) begin
      mem[brd.wr_addr] <= brd.wr_data;
    end
    brd.rd_data <= (brd.rd_addr < 5'(H)) ? mem[brd.rd_addr] : '0;
  end

  wr_t exp_wr[$];
  int  full_before [H+1];
  int  run_k = 0, start_score = 0, model_score = 0, model_lc = 0;
  int  off = -1, run_writes = 0, last_done_off = -1, done_count = 0;
  bit  armed = 1'b0, run_live = 1'b0;
  int  checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic check_score(input string name, input int s);
    check({name, "_ones"}, score_1, s % 10);
    check({name, "_tens"}, score_2, (s / 10) % 10);
    check({name, "_hund"}, score_3, s / 100);
  endtask

  // Golden compaction: survivors keep order and sink to the bottom, k zero rows go on top.
  task automatic arm_run(input bit clr);
    int dst, n;
    exp_wr.delete();
    dst = H - 1;
    n = 0;
    full_before[0] = 0;
    for (int i = 0; i < H; i++) begin
      logic [W-1:0] row;
      row = mem[H-1-i];
      if (row == '1) begin
        n++;
      end else begin
        exp_wr.push_back('{2*i + 1, 5'(dst), row});
        gold[dst] = row;
        dst--;
      end
      full_before[i+1] = n;
    end
    for (int j = 0; j < n; j++) begin
      exp_wr.push_back('{2*H + j, 5'(n - 1 - j), '0});
      gold[n-1-j] = '0;
    end
    run_k         = n;
    start_score   = clr ? 0 : model_score;
    run_writes    = 0;
    last_done_off = -1;
    armed         = 1'b1;
    run_live      = 1'b1;
  endtask

  task automatic compare_run();
    int  n, s, lc;
    bit  last, exp_we;
    last = (off == 2*H + run_k + 1);
    n    = (off / 2 > H) ? H : off / 2;
    s    = (start_score + full_before[n]) % 1000;
    lc   = (full_before[n] > 7) ? 7 : full_before[n];
    check("busy", busy, !last);
    check("done", done, last);
    check_score("score", s);
    check("lines_cleared", lines_cleared, lc);
    if (off < 2*H) check("rd_addr", brd.rd_addr, H - 1 - off / 2);
    exp_we = (exp_wr.size() > 0) && (exp_wr[0].cyc == off);
    check("wr_en", brd.wr_en, exp_we);
    if (brd.wr_en === 1'b1) run_writes++;
    if (exp_we) begin
      if (brd.wr_en === 1'b1) begin
        check("wr_addr", brd.wr_addr, exp_wr[0].addr);
        check("wr_data", brd.wr_data, exp_wr[0].data);
      end
      void'(exp_wr.pop_front());
    end
    if (done === 1'b1) begin
      last_done_off = off;
      done_count++;
    end
    if (last) begin
      model_score = s;
      model_lc    = (run_k > 7) ? 7 : run_k;
      off         = -1;
      run_live    = 1'b0;
    end
  endtask

  task automatic compare_idle();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_wr_en", brd.wr_en, 0);
    check_score("idle_score", model_score);
    check("idle_lines", lines_cleared, model_lc);
    if (done === 1'b1) done_count++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (armed && reset_n) begin
        off   = 0;
        armed = 1'b0;
      end else if (off >= 0) begin
        off++;
      end
      @(negedge clk);
      if (!reset_n) begin
        off = -1; armed = 1'b0; run_live = 1'b0; exp_wr.delete();
        model_score = 0; model_lc = 0;
      end else if (off >= 0) begin
        compare_run();
      end else begin
        compare_idle();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic do_run(input bit clr, input bit noise);
    int guard;
    arm_run(clr);
    start       = 1'b1;
    clear_score = clr;
    tick();
    start       = 1'b0;
    clear_score = 1'b0;
    if (noise) begin
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      clear_score = 1'b1;
      tick();
      clear_score = 1'b0;
    end
    guard = 0;
    while (run_live && guard < 4*H + 20) begin
      tick();
      guard++;
    end
    if (run_live) begin
      check("run_timeout", 1, 0);
      run_live = 1'b0; off = -1; exp_wr.delete();
    end
    for (int r = 0; r < H; r++) check("board_row", mem[r], gold[r]);
  endtask

  initial begin
    int guard, dc;
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", brd.wr_en, 0);
    check("rst_rd_addr", brd.rd_addr, 0);
    check("rst_wr_addr", brd.wr_addr, 0);
    check("rst_wr_data", brd.wr_data, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_score", {score_3, score_2, score_1}, 12'h000);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // Empty board.
    for (int r = 0; r < H; r++) board[r] = '0;
    load();
    do_run(1'b0, 1'b0);
    check("empty_done_cycle", last_done_off, 41);
    check("empty_writes", run_writes, 20);
    check("empty_lines", lines_cleared, 0);
    check("empty_score", {score_3, score_2, score_1}, 12'h000);

    // Two full rows at the bottom, a single block above them.
    for (int r = 0; r < H; r++) board[r] = '0;
    board[19] = '1; board[18] = '1; board[17] = 10'h001;
    load();
    do_run(1'b0, 1'b0);
    check("two_done_cycle", last_done_off, 43);
    check("two_writes", run_writes, 20);
    check("two_lines", lines_cleared, 2);
    check("two_score", {score_3, score_2, score_1}, 12'h002);
    check("two_row19", mem[19], 10'h001);
    check("two_row18", mem[18], 10'h000);
    check("two_row0", mem[0], 10'h000);

    // start and clear_score while busy are ignored.
    for (int r = 0; r < H; r++) board[r] = 10'h2AA;
    board[19] = '1; board[10] = '1;
    load();
    dc = done_count;
    do_run(1'b0, 1'b1);
    check("busy_done_once", done_count - dc, 1);
    check("busy_score", {score_3, score_2, score_1}, 12'h004);

    // clear_score alone in IDLE.
    tick();
    clear_score = 1'b1;
    tick();
    clear_score = 1'b0;
    model_score = 0;
    tick();
    check("clear_idle_score", {score_3, score_2, score_1}, 12'h000);

    // Climb to 998, then wrap through 999.
    for (int i = 0; i < 49; i++) begin
      for (int r = 0; r < H; r++) board[r] = '1;
      load();
      do_run(1'b0, 1'b0);
      if (i == 0) check("sat_lines", lines_cleared, 7);
    end
    check("score_980", {score_3, score_2, score_1}, 12'h980);
    for (int r = 0; r < H; r++) board[r] = (r >= 2) ? '1 : 10'h0F0;
    load();
    do_run(1'b0, 1'b0);
    check("score_998", {score_3, score_2, score_1}, 12'h998);
    for (int r = 0; r < H; r++) board[r] = 10'h3FE;
    board[19] = '1; board[15] = '1; board[10] = '1; board[3] = '1;
    load();
    do_run(1'b0, 1'b0);
    check("wrap_score", {score_3, score_2, score_1}, 12'h002);
    check("wrap_lines", lines_cleared, 4);
    check("wrap_done_cycle", last_done_off, 45);

    // Reset in the first FILL cycle abandons the run.
    for (int r = 0; r < H; r++) board[r] = (r >= 17) ? '1 : 10'h155;
    load();
    arm_run(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (off != 2*H && guard < 4*H) begin
      tick();
      guard++;
    end
    check("abort_reached_fill", off, 2*H);
    reset_n = 1'b0;
    #1;
    check("abort_wr_en", brd.wr_en, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_lines", lines_cleared, 0);
    check("abort_score", {score_3, score_2, score_1}, 12'h000);
    tick();
    tick();
    reset_n = 1'b1;
    check("abort_row2_kept", mem[2], 10'h155);
    check("abort_row19", mem[19], 10'h155);
    do_run(1'b0, 1'b0);
    check("after_abort_done_cycle", last_done_off, 41);
    check("after_abort_score", {score_3, score_2, score_1}, 12'h000);

    // Random boards.
    for (int t = 0; t < 1000; t++) begin
      for (int r = 0; r < H; r++) begin
        int sel;
        sel = $urandom_range(0, 3);
        board[r] = (sel == 0) ? '1 : (sel == 1) ? '0 : W'($urandom);
      end
      load();
      do_run($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
